// File: rtl/screen_uart_tx.sv
// Serial LCD transmitter: shifts pre-formatted 10-bit UART frames out LSB-first on tx.
// Optional macro SCREEN_UART_TX_STOP2_EN appends a second stop-bit period.
module screen_uart_tx #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frameValid,
  input  logic [9:0] frameData,
  output logic       frameReady,
  output logic       tx,
  output logic       busy,
  output logic       frameErr
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
`ifdef SCREEN_UART_TX_STOP2_EN
  localparam logic [1:0] StStop2 = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  // Holds the bits still to be sent; the bit on the line lives in tx_q.
  logic [8:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic baud_last;
  assign baud_last = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (frameValid && ready_q) begin
          shift_d    = frameData[9:1];
          tx_d       = frameData[0];
          baud_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          state_d    = StShift;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          err_d      = frameData[0] | ~frameData[9];
        end
      end

      StShift: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            tx_d = 1'b1;
`ifdef SCREEN_UART_TX_STOP2_EN
            state_d   = StStop2;
            bit_cnt_d = 4'd10;
`else
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

`ifdef SCREEN_UART_TX_STOP2_EN
      StStop2: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          state_d    = StIdle;
          ready_d    = 1'b1;
          busy_d     = 1'b0;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
`endif

      default: begin
        state_d    = StIdle;
        baud_cnt_d = '0;
        bit_cnt_d  = 4'd0;
        tx_d       = 1'b1;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign tx         = tx_q;
  assign frameReady = ready_q;
  assign busy       = busy_q;
  assign frameErr   = err_q;

endmodule

// File: tb/tb_screen_uart_tx.sv
// Bench for screen_uart_tx: frame table, hand-written corner sequences and random traffic
// checked every cycle against a queue-based line model.
module tb_screen_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef SCREEN_UART_TX_STOP2_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned NS = NB * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frameValid = 1'b0;
  logic [9:0] frameData = '0;
  logic       frameReady, tx, busy, frameErr;

  screen_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frameValid (frameValid),
    .frameData  (frameData),
    .frameReady (frameReady),
    .tx         (tx),
    .busy       (busy),
    .frameErr   (frameErr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Line model: each accepted frame becomes a queue of per-cycle tx levels.
  bit m_q[$];
  bit m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b0, m_err = 1'b0;

  typedef struct {
    logic [9:0] frame;
    logic [0:9] seq;   // expected line levels in transmission order
    logic       err;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b0; m_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_err = 1'b0;
      if (frameValid && m_ready) begin
        for (int b = 0; b < int'(NB); b++)
          for (int c = 0; c < int'(CPB); c++) m_q.push_back(b < 10 ? frameData[b] : 1'b1);
        m_err = (frameData[0] != 1'b0) || (frameData[9] != 1'b1);
      end
      if (m_q.size() > 0) begin
        m_tx = m_q.pop_front(); m_busy = 1'b1; m_ready = 1'b0;
      end else begin
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
      end
    end
    #1;
    chk("model tx/busy/ready/err", {28'd0, tx, busy, frameReady, frameErr},
        {28'd0, m_tx, m_busy, m_ready, m_err});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (frameReady !== 1'b1 && n < 200) begin step(); n++; end
    chk("wait_ready", frameReady, 1);
  endtask

  task automatic send_vec(input vec_t v, input string name);
    logic tx_w[NS];
    logic err_w[NS];
    logic busy_ok = 1'b1;
    logic err_rest = 1'b0;
    wait_ready();
    frameData = v.frame; frameValid = 1'b1;
    step();
    frameValid = 1'b0; frameData = 10'($urandom);
    for (int k = 0; k < int'(NS); k++) begin
      tx_w[k] = tx; err_w[k] = frameErr;
      if (busy !== 1'b1 || frameReady !== 1'b0) busy_ok = 1'b0;
      if (k != int'(NS) - 1) begin frameData = 10'($urandom); step(); end
    end
    step();
    chk({name, " return tx/busy/ready"}, {tx, busy, frameReady}, 3'b101);
    for (int i = 0; i < int'(NB); i++) begin
      logic e = (i < 10) ? v.seq[i] : 1'b1;
      chk($sformatf("%s bit%0d", name, i),
          {tx_w[i*CPB], tx_w[i*CPB+1], tx_w[i*CPB+2], tx_w[i*CPB+3]}, {4{e}});
    end
    for (int k = 1; k < int'(NS); k++) err_rest |= err_w[k];
    chk({name, " err pulse"}, {err_w[0], err_rest}, {v.err, 1'b0});
    chk({name, " busy held"}, busy_ok, 1);
  endtask

  initial begin
    int n;
    logic busy_prev;
    vecs[0] = '{frame: 10'b1_01010011_0, seq: 10'b0110010101, err: 1'b0};
    vecs[1] = '{frame: 10'h3FC,          seq: 10'b0011111111, err: 1'b0};
    vecs[2] = '{frame: 10'h0FF,          seq: 10'b1111111100, err: 1'b1};
    vecs[3] = '{frame: 10'h201,          seq: 10'b1000000001, err: 1'b1};
    vecs[4] = '{frame: 10'h000,          seq: 10'b0000000000, err: 1'b1};
    vecs[5] = '{frame: 10'h3FE,          seq: 10'b0111111111, err: 1'b0};

    // Reset defaults
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset outputs", {tx, busy, frameErr, frameReady}, 4'b1000);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("ready after release", frameReady, 1);

    for (int i = 0; i < 6; i++) send_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back with valid held high
    wait_ready();
    frameData = 10'h3FC; frameValid = 1'b1;
    step();
    chk("b2b first accept", busy, 1);
    busy_prev = busy;
    n = 0;
    while (n < 200) begin
      step(); n++;
      if (!busy_prev && busy) break;
      busy_prev = busy;
    end
    chk("b2b accept spacing", n, NS + 1);
    chk("b2b second start bit", tx, 0);
    frameValid = 1'b0;
    for (int i = 0; i < int'(NS); i++) step();

    // Reset mid-frame during bit 4
    wait_ready();
    frameData = 10'h3FC; frameValid = 1'b1;
    step();
    frameValid = 1'b0;
    for (int i = 0; i < int'(4 * CPB); i++) step();
    chk("pre-reset in frame", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async reset tx/busy/ready", {tx, busy, frameReady}, 3'b100);
    step(); step();
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("ready after mid reset", frameReady, 1);
    send_vec(vecs[1], "post-reset");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      frameValid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) frameData = {1'b1, 8'($urandom), 1'b0};
      else frameData = 10'($urandom);
      step();
    end
    frameValid = 1'b0;
    for (int i = 0; i < int'(NS) + 2; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
